ahb_sram_backend: RTL

//  Word-addressed SRAM target behind the generic AHB slave front end: consumes its rd_en/wr_en/address/wr_data

---
 rtl/ahb_pkg.sv | 18 +
 rtl/ahb_sram_array.sv | 25 ++
 rtl/ahb_sram_backend.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the SRAM back-end state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        SRAM_IDLE = 2'b00,
        SRAM_WAIT = 2'b01,
        SRAM_ERR  = 2'b10
    } sram_state_t;

endpackage

// File: rtl/ahb_sram_array.sv
// Word storage: one synchronous write port, one asynchronous read port, contents not reset.
module ahb_sram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                     HCLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port: commits on the rising edge when enabled.
    always_ff @(posedge HCLK) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_sram_backend.sv
// SRAM target behind the AHB slave front end: wait states, range/alignment checks, two-cycle ERROR.
// Optional read-only low region enabled by defining AHB_SRAM_RO_EN.
module ahb_sram_backend
    import ahb_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    WAIT_STATES = 1,
    parameter int                    RO_WORDS    = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ready,
    output logic                  error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFS_W = $clog2(BYTES);

    localparam logic [1:0] ST_IDLE = SRAM_IDLE;
    localparam logic [1:0] ST_WAIT = SRAM_WAIT;
    localparam logic [1:0] ST_ERR  = SRAM_ERR;

    localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(DEPTH * BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [IDX_W-1:0]      RO_LIMIT   = IDX_W'(RO_WORDS);
    localparam logic [3:0]            WS_LOAD    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

`ifdef AHB_SRAM_RO_EN
    localparam logic RO_EN = 1'b1;
`else
    localparam logic RO_EN = 1'b0;
`endif

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [3:0]            cnt_r;
    logic [3:0]            cnt_nxt_s;
    logic [IDX_W-1:0]      idx_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  dir_r;
    logic                  latch_s;

    logic                  req_s;
    logic                  bad_s;
    logic [ADDR_WIDTH-1:0] offset_s;
    logic [IDX_W-1:0]      index_s;

    logic                  mem_we_s;
    logic [IDX_W-1:0]      mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [IDX_W-1:0]      mem_raddr_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;

    assign req_s    = rd_en | wr_en;
    assign offset_s = address - BASE_ADDR;
    assign index_s  = IDX_W'(offset_s >> OFS_W);

    // A write into the protected low words is treated exactly like an out-of-range access.
    assign bad_s = (address < BASE_ADDR)
                 | (offset_s >= SPAN)
                 | (|(address & ALIGN_MASK))
                 | (RO_EN & wr_en & (index_s < RO_LIMIT));

    // Next-state, response and array-port decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        ready       = 1'b1;
        error       = HRESP_OKAY;
        rd_data     = '0;
        mem_we_s    = 1'b0;
        mem_waddr_s = index_s;
        mem_wdata_s = wr_data;
        mem_raddr_s = index_s;
        case (state_r)
            ST_IDLE: begin
                if (req_s && bad_s) begin
                    ready       = 1'b0;
                    error       = HRESP_ERROR;
                    state_nxt_s = ST_ERR;
                end else if (req_s && (WAIT_STATES == 0)) begin
                    if (wr_en) begin
                        mem_we_s = 1'b1;
                    end else begin
                        rd_data = mem_rdata_s;
                    end
                end else if (req_s) begin
                    ready       = 1'b0;
                    latch_s     = 1'b1;
                    cnt_nxt_s   = WS_LOAD;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                mem_raddr_s = idx_r;
                mem_waddr_s = idx_r;
                mem_wdata_s = data_r;
                if (cnt_r != 4'd0) begin
                    ready     = 1'b0;
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    if (dir_r) begin
                        mem_we_s = 1'b1;
                    end else begin
                        rd_data = mem_rdata_s;
                    end
                end
            end
            ST_ERR: begin
                error       = HRESP_ERROR;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, wait counter and request latches; a reset drops any pending write.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            data_r  <= '0;
            dir_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (latch_s) begin
                idx_r  <= index_s;
                data_r <= wr_data;
                dir_r  <= wr_en;
            end
        end
    end

    ahb_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .HCLK  (HCLK),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .raddr (mem_raddr_s),
        .rdata (mem_rdata_s)
    );

endmodule
